reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ID_SIZE, default 2: entry-ID width; the buffer depth N = 2**ID_SIZE.
REQ-002 Parameter REG_ADDRESS_SIZE, default 5: destination register address width.
REQ-003 Parameter REGISTER_SIZE, default 32: result value width.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 alloc_valid  input  1: request to allocate the next entry.
REQ-007 alloc_addr  input  REG_ADDRESS_SIZE: destination register of the allocating instruction.
REQ-008 alloc_wr  input  1: the allocating instruction writes a register.
REQ-009 alloc_ready  output  1: an entry is free.
REQ-010 alloc_id  output  ID_SIZE: the ID granted on an accepted allocation; equals tail.
REQ-011 wb_valid, wb_id, wb_value  input  1/ID_SIZE/REGISTER_SIZE: writeback of a result into the entry wb_id.
REQ-012 commit_valid  output  1: the head entry is complete.
REQ-013 commit_ready  input  1: the consumer accepts the commit.
REQ-014 commit_addr, commit_wr, commit_value  output  REG_ADDRESS_SIZE/1/REGISTER_SIZE: fields of the head entry.
REQ-015 flush  input  1: discard all entries.
REQ-016 tail  output  ID_SIZE: next allocation slot, used by dependency lookup for youngest-first ordering.
REQ-017 unavailable  output  [N-1:0][REG_ADDRESS_SIZE+1+ID_SIZE+1-1:0]: slot i carries {addr, wr, id=i, pending}.
REQ-018 available  output  [N-1:0][REGISTER_SIZE+REG_ADDRESS_SIZE+1+ID_SIZE+1-1:0]: slot i carries {value, addr, wr, id=i, done}.

Function
REQ-019 Circular buffer: head pointer, tail pointer and count (0..N) shall be kept; both pointers wrap from N-1 to 0.
REQ-020 alloc_ready shall equal (count<N), evaluated on the current count only; a same-cycle commit shall not enable allocation while the buffer is full.
REQ-021 An accepted allocation (alloc_valid && alloc_ready) shall write addr and wr into slot tail, set occupied=1 and done=0, and advance tail at that edge.
REQ-022 A writeback shall, at the edge, set done=1 and store value in slot wb_id only if that slot is occupied and not done; otherwise it shall be ignored.
REQ-023 Pending bit of unavailable[i] shall be occupied&&!done; done bit of available[i] shall be occupied&&done; all other fields of a slot shall be 0 when that slot is unoccupied.
REQ-024 commit_valid shall be 1 when count>0 and the head slot has done=1; commit fields shall be the head slot's fields, and 0 otherwise.
REQ-025 On commit_valid && commit_ready the head slot shall be cleared and head shall advance; an entry whose wr=0 shall commit identically.
REQ-026 Latency: each of allocate, writeback and commit shall be visible on the exported arrays and the commit port in the cycle after the edge; there shall be no combinational path from wb_* to commit_valid.
REQ-027 When allocation and commit occur in the same cycle, count shall stay unchanged, and both pointers shall advance.
REQ-028 A writeback to the head slot in the same cycle it is committing is impossible, because commit requires done=1 already, and shall require no special handling.
REQ-029 flush shall take priority over allocate, writeback and commit: at the edge it clears all slots and sets head=tail=count=0.

Reset
REQ-030 While reset is high at an edge, head, tail and count shall be 0, all slots shall be cleared, and every output shall read 0 except alloc_ready=1.
REQ-031 Reset asserted mid-operation shall discard in-flight entries exactly as flush does; reset shall dominate flush.

Structure
REQ-032 Package rob_pkg shall hold default widths plus localparam field offsets and entry widths for both export formats, shared with the dependency-lookup logic.
REQ-033 The design shall have one sub-module, rob_slot, holding one entry's storage (addr, wr, value, occupied, done) with alloc/wb/clear controls; reorder_buffer shall instantiate N of them plus the pointer logic.

Verification
REQ-034 After reset, allocate addr=3 wr=1 -> next cycle: unavailable[0]={3,1,0,1}, tail=1, alloc_ready=1.
REQ-035 Then wb_id=0 wb_value=0xDEADBEEF -> next cycle: unavailable[0] pending=0, available[0]={0xDEADBEEF,3,1,0,1}, commit_valid=1, commit_value=0xDEADBEEF.
REQ-036 Allocate 4 entries without commit -> alloc_ready=0, count=4; a 5th alloc_valid is ignored and tail stays 0.
REQ-037 Out-of-order writeback: write back ids 2 then 1 while id 0 is pending -> commit_valid stays 0 until id 0 is done, after which ids 0,1,2 commit in order over 3 cycles.
REQ-038 With head=3, tail wrapped to 1 and count=2, allocate and commit in the same cycle -> head=0, tail=2, count=2.
REQ-039 Flush with 3 entries pending and a simultaneous wb/alloc -> next cycle all export bits are 0, tail=0 and commit_valid=0.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg -- shared definitions for the reorder buffer and its consumers.
//
// Holds the default widths and the bit layout of the two exported slot
// formats, so that the dependency-lookup logic can pick fields out of
// the 'unavailable' and 'available' arrays without hard-coding offsets.
//
//   unavailable[i] = {addr, wr, id, pending}
//   available[i]   = {value, addr, wr, id, done}
//
// The localparams describe the default configuration; the functions give
// the same numbers for any other parameterisation.
package rob_pkg;

    localparam int ROB_ID_SIZE          = 2;
    localparam int ROB_REG_ADDRESS_SIZE = 5;
    localparam int ROB_REGISTER_SIZE    = 32;

    // Unavailable (not yet written back) entry format, LSB first.
    localparam int UNAV_PENDING_POS = 0;
    localparam int UNAV_ID_LSB      = 1;
    localparam int UNAV_WR_POS      = UNAV_ID_LSB + ROB_ID_SIZE;
    localparam int UNAV_ADDR_LSB    = UNAV_WR_POS + 1;
    localparam int UNAV_WIDTH       = UNAV_ADDR_LSB + ROB_REG_ADDRESS_SIZE;

    // Available (written back, result present) entry format, LSB first.
    localparam int AVAIL_DONE_POS   = 0;
    localparam int AVAIL_ID_LSB     = 1;
    localparam int AVAIL_WR_POS     = AVAIL_ID_LSB + ROB_ID_SIZE;
    localparam int AVAIL_ADDR_LSB   = AVAIL_WR_POS + 1;
    localparam int AVAIL_VALUE_LSB  = AVAIL_ADDR_LSB + ROB_REG_ADDRESS_SIZE;
    localparam int AVAIL_WIDTH      = AVAIL_VALUE_LSB + ROB_REGISTER_SIZE;

    // Width of one unavailable entry for arbitrary field sizes.
    function automatic int unav_width(input int id_size, input int addr_size);
        return addr_size + 1 + id_size + 1;
    endfunction

    // Width of one available entry for arbitrary field sizes.
    function automatic int avail_width(input int id_size, input int addr_size,
                                       input int value_size);
        return value_size + addr_size + 1 + id_size + 1;
    endfunction

endpackage

// File: rtl/rob_slot.sv
// rob_slot -- storage for a single reorder-buffer entry.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   clear          empty the slot (commit of this slot, or flush)
//   alloc          claim the slot for a new instruction (alloc_addr/alloc_wr)
//   wb, wb_value   deliver the instruction's result
//   addr, wr, value, occupied, done   current contents of the slot
//
// Fields of an unoccupied slot are always held at zero so the parent can
// export them without further masking.
module rob_slot
    import rob_pkg::*;
#(
    parameter int REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
    parameter int REGISTER_SIZE    = ROB_REGISTER_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        alloc,
    input  logic [REG_ADDRESS_SIZE-1:0] alloc_addr,
    input  logic                        alloc_wr,
    input  logic                        wb,
    input  logic [REGISTER_SIZE-1:0]    wb_value,
    output logic [REG_ADDRESS_SIZE-1:0] addr,
    output logic                        wr,
    output logic [REGISTER_SIZE-1:0]    value,
    output logic                        occupied,
    output logic                        done
);

    // A writeback only lands on a live entry still waiting for its result;
    // stale or duplicate writebacks are dropped here.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            addr     <= '0;
            wr       <= 1'b0;
            value    <= '0;
            occupied <= 1'b0;
            done     <= 1'b0;
        end else if (alloc) begin
            addr     <= alloc_addr;
            wr       <= alloc_wr;
            value    <= '0;
            occupied <= 1'b1;
            done     <= 1'b0;
        end else if (wb && occupied && !done) begin
            value    <= wb_value;
            done     <= 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer -- in-order commit buffer for out-of-order results.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   alloc_valid/addr/wr, alloc_ready allocate the entry at 'tail'
//   alloc_id                         ID granted to the allocation (= tail)
//   wb_valid/id/value                result writeback into entry wb_id
//   commit_valid/ready               head entry complete / consumer accepts
//   commit_addr/wr/value             fields of the head entry
//   flush                            discard every entry
//   tail                             next allocation slot
//   unavailable[i]                   {addr, wr, id, pending} of slot i
//   available[i]                     {value, addr, wr, id, done} of slot i
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ID_SIZE          = ROB_ID_SIZE,
    parameter int REG_ADDRESS_SIZE = ROB_REG_ADDRESS_SIZE,
    parameter int REGISTER_SIZE    = ROB_REGISTER_SIZE,
    localparam int N               = 2 ** ID_SIZE,
    localparam int UW              = unav_width(ID_SIZE, REG_ADDRESS_SIZE),
    localparam int AW              = avail_width(ID_SIZE, REG_ADDRESS_SIZE, REGISTER_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_valid,
    input  logic [REG_ADDRESS_SIZE-1:0] alloc_addr,
    input  logic                        alloc_wr,
    output logic                        alloc_ready,
    output logic [ID_SIZE-1:0]          alloc_id,
    input  logic                        wb_valid,
    input  logic [ID_SIZE-1:0]          wb_id,
    input  logic [REGISTER_SIZE-1:0]    wb_value,
    output logic                        commit_valid,
    input  logic                        commit_ready,
    output logic [REG_ADDRESS_SIZE-1:0] commit_addr,
    output logic                        commit_wr,
    output logic [REGISTER_SIZE-1:0]    commit_value,
    input  logic                        flush,
    output logic [ID_SIZE-1:0]          tail,
    output logic [N-1:0][UW-1:0]        unavailable,
    output logic [N-1:0][AW-1:0]        available
);

    localparam logic [ID_SIZE:0] FULL = (ID_SIZE + 1)'(N);

    logic [ID_SIZE-1:0] head;
    logic [ID_SIZE:0]   count;

    logic [REG_ADDRESS_SIZE-1:0] slot_addr     [N];
    logic                        slot_wr       [N];
    logic [REGISTER_SIZE-1:0]    slot_value    [N];
    logic                        slot_occupied [N];
    logic                        slot_done     [N];

    logic alloc_fire;
    logic commit_fire;

    // Readiness looks at the current count only, so a full buffer never
    // accepts an allocation on the strength of a same-cycle commit.
    assign alloc_ready = (count < FULL);
    assign alloc_id    = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Commit depends only on registered slot state, so there is no
    // combinational path from the writeback port to commit_valid.
    assign commit_valid = (count != '0) && slot_done[head];
    assign commit_fire  = commit_valid && commit_ready;
    assign commit_addr  = commit_valid ? slot_addr[head]  : '0;
    assign commit_wr    = commit_valid ? slot_wr[head]    : 1'b0;
    assign commit_value = commit_valid ? slot_value[head] : '0;

    // One storage slot per ID. Flush suppresses allocate and writeback and
    // clears every slot; a commit clears only the head slot.
    for (genvar i = 0; i < N; i++) begin : g_slot
        logic [ID_SIZE-1:0] slot_id;
        assign slot_id = ID_SIZE'(i);

        rob_slot #(
            .REG_ADDRESS_SIZE(REG_ADDRESS_SIZE),
            .REGISTER_SIZE   (REGISTER_SIZE)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .clear     (flush || (commit_fire && (head == slot_id))),
            .alloc     (!flush && alloc_fire && (tail == slot_id)),
            .alloc_addr(alloc_addr),
            .alloc_wr  (alloc_wr),
            .wb        (!flush && wb_valid && (wb_id == slot_id)),
            .wb_value  (wb_value),
            .addr      (slot_addr[i]),
            .wr        (slot_wr[i]),
            .value     (slot_value[i]),
            .occupied  (slot_occupied[i]),
            .done      (slot_done[i])
        );

        // The ID field reads zero on an empty slot, like every other field.
        assign unavailable[i] = {slot_addr[i], slot_wr[i],
                                 slot_occupied[i] ? slot_id : '0,
                                 slot_occupied[i] && !slot_done[i]};
        assign available[i]   = {slot_value[i], slot_addr[i], slot_wr[i],
                                 slot_occupied[i] ? slot_id : '0,
                                 slot_occupied[i] && slot_done[i]};
    end

    // Pointer and occupancy bookkeeping. Pointers are exactly ID_SIZE bits
    // wide, so incrementing past N-1 wraps to 0 on its own.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (commit_fire) begin
                head <= head + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer -- directed self-checking bench for reorder_buffer.
//
// Runs the default configuration (4 entries, 5-bit register addresses,
// 32-bit values) through allocation, writeback, in-order commit, wrap,
// simultaneous allocate/commit, flush and reset-over-flush.
module tb_reorder_buffer;

    localparam int ID_SIZE = 2;
    localparam int RA      = 5;
    localparam int RS      = 32;
    localparam int N       = 4;
    localparam int UW      = RA + 1 + ID_SIZE + 1;
    localparam int AW      = RS + RA + 1 + ID_SIZE + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  alloc_valid;
    logic [RA-1:0]         alloc_addr;
    logic                  alloc_wr;
    logic                  alloc_ready;
    logic [ID_SIZE-1:0]    alloc_id;
    logic                  wb_valid;
    logic [ID_SIZE-1:0]    wb_id;
    logic [RS-1:0]         wb_value;
    logic                  commit_valid;
    logic                  commit_ready;
    logic [RA-1:0]         commit_addr;
    logic                  commit_wr;
    logic [RS-1:0]         commit_value;
    logic                  flush;
    logic [ID_SIZE-1:0]    tail;
    logic [N-1:0][UW-1:0]  unavailable;
    logic [N-1:0][AW-1:0]  available;

    int checkCount = 0;
    int passCount  = 0;

    reorder_buffer #(
        .ID_SIZE         (ID_SIZE),
        .REG_ADDRESS_SIZE(RA),
        .REGISTER_SIZE   (RS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_wr    (alloc_wr),
        .alloc_ready (alloc_ready),
        .alloc_id    (alloc_id),
        .wb_valid    (wb_valid),
        .wb_id       (wb_id),
        .wb_value    (wb_value),
        .commit_valid(commit_valid),
        .commit_ready(commit_ready),
        .commit_addr (commit_addr),
        .commit_wr   (commit_wr),
        .commit_value(commit_value),
        .flush       (flush),
        .tail        (tail),
        .unavailable (unavailable),
        .available   (available)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, clock them in, and settle just past the edge.
    task automatic applyStimulus(input logic av, input logic [RA-1:0] aa, input logic aw,
                                 input logic wv, input logic [ID_SIZE-1:0] wi,
                                 input logic [RS-1:0] wval, input logic cr, input logic fl);
        alloc_valid  = av;
        alloc_addr   = aa;
        alloc_wr     = aw;
        wb_valid     = wv;
        wb_id        = wi;
        wb_value     = wval;
        commit_ready = cr;
        flush        = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        applyReset();

        $display("[TB] reset state");
        checkOutput("rst_alloc_ready", 256'(alloc_ready), 256'(1'b1));
        checkOutput("rst_tail", 256'(tail), 256'(2'd0));
        checkOutput("rst_alloc_id", 256'(alloc_id), 256'(2'd0));
        checkOutput("rst_commit_valid", 256'(commit_valid), 256'(1'b0));
        checkOutput("rst_commit_value", 256'(commit_value), 256'(32'd0));
        checkOutput("rst_unavailable", 256'(unavailable), 256'(0));
        checkOutput("rst_available", 256'(available), 256'(0));

        $display("[TB] single allocate, writeback, commit");
        applyStimulus(1, 5'd3, 1, 0, 0, 0, 0, 0);
        checkOutput("a1_unav0", 256'(unavailable[0]), 256'({5'd3, 1'b1, 2'd0, 1'b1}));
        checkOutput("a1_tail", 256'(tail), 256'(2'd1));
        checkOutput("a1_alloc_ready", 256'(alloc_ready), 256'(1'b1));
        checkOutput("a1_commit_valid", 256'(commit_valid), 256'(1'b0));

        applyStimulus(0, 0, 0, 1, 2'd0, 32'hDEADBEEF, 0, 0);
        checkOutput("wb_unav0", 256'(unavailable[0]), 256'({5'd3, 1'b1, 2'd0, 1'b0}));
        checkOutput("wb_avail0", 256'(available[0]),
                    256'({32'hDEADBEEF, 5'd3, 1'b1, 2'd0, 1'b1}));
        checkOutput("wb_commit_valid", 256'(commit_valid), 256'(1'b1));
        checkOutput("wb_commit_value", 256'(commit_value), 256'(32'hDEADBEEF));
        checkOutput("wb_commit_addr", 256'(commit_addr), 256'(5'd3));
        checkOutput("wb_commit_wr", 256'(commit_wr), 256'(1'b1));

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("c1_commit_valid", 256'(commit_valid), 256'(1'b0));
        checkOutput("c1_unav", 256'(unavailable), 256'(0));
        checkOutput("c1_avail", 256'(available), 256'(0));
        checkOutput("c1_tail", 256'(tail), 256'(2'd1));

        $display("[TB] fill to capacity");
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, RA'(10 + i), (i != 3), 0, 0, 0, 0, 0);
        end
        checkOutput("full_alloc_ready", 256'(alloc_ready), 256'(1'b0));
        checkOutput("full_tail", 256'(tail), 256'(2'd0));
        checkOutput("full_count", 256'(dut.count), 256'(3'd4));
        checkOutput("full_unav3", 256'(unavailable[3]), 256'({5'd13, 1'b0, 2'd3, 1'b1}));

        applyStimulus(1, 5'd31, 1, 0, 0, 0, 0, 0);
        checkOutput("over_tail", 256'(tail), 256'(2'd0));
        checkOutput("over_unav0", 256'(unavailable[0]), 256'({5'd10, 1'b1, 2'd0, 1'b1}));
        checkOutput("over_count", 256'(dut.count), 256'(3'd4));

        $display("[TB] out-of-order writeback");
        applyStimulus(0, 0, 0, 1, 2'd2, 32'h222, 0, 0);
        checkOutput("ooo2_commit_valid", 256'(commit_valid), 256'(1'b0));
        checkOutput("ooo2_avail2", 256'(available[2]), 256'({32'h222, 5'd12, 1'b1, 2'd2, 1'b1}));
        applyStimulus(0, 0, 0, 1, 2'd1, 32'h111, 0, 0);
        checkOutput("ooo1_commit_valid", 256'(commit_valid), 256'(1'b0));
        applyStimulus(0, 0, 0, 1, 2'd0, 32'h100, 0, 0);
        checkOutput("ooo0_commit_valid", 256'(commit_valid), 256'(1'b1));
        checkOutput("ooo0_commit_value", 256'(commit_value), 256'(32'h100));
        checkOutput("ooo0_commit_addr", 256'(commit_addr), 256'(5'd10));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("seq1_commit_value", 256'(commit_value), 256'(32'h111));
        checkOutput("seq1_commit_addr", 256'(commit_addr), 256'(5'd11));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("seq2_commit_value", 256'(commit_value), 256'(32'h222));
        checkOutput("seq2_commit_addr", 256'(commit_addr), 256'(5'd12));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("seq3_commit_valid", 256'(commit_valid), 256'(1'b0));
        checkOutput("seq3_alloc_ready", 256'(alloc_ready), 256'(1'b1));
        checkOutput("seq3_head", 256'(dut.head), 256'(2'd3));

        $display("[TB] wrap with simultaneous allocate and commit");
        applyStimulus(1, 5'd20, 1, 0, 0, 0, 0, 0);
        checkOutput("wrap_tail", 256'(tail), 256'(2'd1));
        checkOutput("wrap_count", 256'(dut.count), 256'(3'd2));
        applyStimulus(0, 0, 0, 1, 2'd3, 32'h333, 0, 0);
        checkOutput("wr0_commit_valid", 256'(commit_valid), 256'(1'b1));
        checkOutput("wr0_commit_wr", 256'(commit_wr), 256'(1'b0));
        checkOutput("wr0_commit_addr", 256'(commit_addr), 256'(5'd13));
        checkOutput("wr0_commit_value", 256'(commit_value), 256'(32'h333));
        applyStimulus(1, 5'd21, 1, 0, 0, 0, 1, 0);
        checkOutput("both_head", 256'(dut.head), 256'(2'd0));
        checkOutput("both_tail", 256'(tail), 256'(2'd2));
        checkOutput("both_count", 256'(dut.count), 256'(3'd2));
        checkOutput("both_commit_valid", 256'(commit_valid), 256'(1'b0));
        checkOutput("both_unav3", 256'(unavailable[3]), 256'(0));
        checkOutput("both_unav1", 256'(unavailable[1]), 256'({5'd21, 1'b1, 2'd1, 1'b1}));

        $display("[TB] flush over allocate and writeback");
        applyStimulus(1, 5'd22, 1, 0, 0, 0, 0, 0);
        checkOutput("pre_flush_count", 256'(dut.count), 256'(3'd3));
        applyStimulus(1, 5'd23, 1, 1, 2'd0, 32'h999, 1, 1);
        checkOutput("flush_unav", 256'(unavailable), 256'(0));
        checkOutput("flush_avail", 256'(available), 256'(0));
        checkOutput("flush_tail", 256'(tail), 256'(2'd0));
        checkOutput("flush_commit_valid", 256'(commit_valid), 256'(1'b0));
        checkOutput("flush_alloc_ready", 256'(alloc_ready), 256'(1'b1));

        $display("[TB] reset over flush mid-operation");
        applyStimulus(1, 5'd5, 1, 0, 0, 0, 0, 0);
        checkOutput("mid_tail", 256'(tail), 256'(2'd1));
        reset = 1'b1;
        applyStimulus(1, 5'd6, 1, 0, 0, 0, 0, 1);
        reset = 1'b0;
        checkOutput("mid_rst_tail", 256'(tail), 256'(2'd0));
        checkOutput("mid_rst_unav", 256'(unavailable), 256'(0));
        checkOutput("mid_rst_alloc_ready", 256'(alloc_ready), 256'(1'b1));
        checkOutput("mid_rst_commit_valid", 256'(commit_valid), 256'(1'b0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
